// File: rtl/scan_test_pkg.sv
// rtl/scan_test_pkg.sv - shared types and constants for the partial-scan test controller
package scan_test_pkg;

  localparam int SIG_W = 16;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  // Same polynomial as Fibonacci tap positions (bit-reversed mask)
  localparam logic [15:0] FIB_TAPS = 16'h002D;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_SHIFT,
    ST_FLUSH,
    ST_COMPARE,
    ST_DONE
  } state_t;

  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? SEED_DEFAULT : s;
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// rtl/lfsr16_step.sv - one combinational step of a 16-bit LFSR, PRPG (Fibonacci) or MISR (Galois)
module lfsr16_step
  import scan_test_pkg::*;
#(
  parameter bit MISR_MODE = 1'b0
) (
  input  logic [15:0] cur,
  input  logic        serial_in,
  output logic [15:0] nxt
);

  logic        fib_fb;
  logic [15:0] fib_next;
  logic [15:0] gal_next;

  // serial_in is XORed into the feedback bit in PRPG mode; tie low for a pure generator
  assign fib_fb   = (^(cur & FIB_TAPS)) ^ serial_in;
  assign fib_next = {fib_fb, cur[15:1]};

  assign gal_next = {1'b0, cur[15:1]}
                  ^ (cur[0] ? LFSR_POLY : 16'h0000)
                  ^ {15'b0, serial_in};

  assign nxt = MISR_MODE ? gal_next : fib_next;

endmodule

// File: rtl/partial_scan_ctrl.sv
// rtl/partial_scan_ctrl.sv - scan load/capture/unload sequencer with LFSR stimulus and MISR check
module partial_scan_ctrl
  import scan_test_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int PAT_W     = 8,
  parameter int SIG_W     = scan_test_pkg::SIG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_go,
  input  logic [PAT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0] seed,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             scan_out,
  output logic             NbarT,
  output logic             scan_in,
  output logic             test_active,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   shift_cnt, shift_cnt_n;
  logic [PAT_W-1:0]   pat_cnt, pat_cnt_n;
  logic [PAT_W-1:0]   n_lat, n_lat_n;
  logic [SIG_W-1:0]   prpg, prpg_n;
  logic [SIG_W-1:0]   misr, misr_n;
  logic               pass_n;

  logic [SIG_W-1:0]   prpg_step;
  logic [SIG_W-1:0]   misr_step;
  logic [PAT_W-1:0]   pat_inc;
  logic               shift_last;

  lfsr16_step #(.MISR_MODE(1'b0)) u_prpg (
    .cur       (prpg),
    .serial_in (1'b0),
    .nxt       (prpg_step)
  );

  lfsr16_step #(.MISR_MODE(1'b1)) u_misr (
    .cur       (misr),
    .serial_in (scan_out),
    .nxt       (misr_step)
  );

  assign pat_inc    = pat_cnt + 1'b1;
  assign shift_last = (shift_cnt == CNT_LAST);
  assign signature  = misr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      n_lat     <= '0;
      prpg      <= '0;
      misr      <= '0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_cnt <= shift_cnt_n;
      pat_cnt   <= pat_cnt_n;
      n_lat     <= n_lat_n;
      prpg      <= prpg_n;
      misr      <= misr_n;
      pass      <= pass_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_cnt_n = shift_cnt;
    pat_cnt_n   = pat_cnt;
    n_lat_n     = n_lat;
    prpg_n      = prpg;
    misr_n      = misr;
    pass_n      = pass;
    NbarT       = 1'b0;
    scan_in     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (test_go) begin
          n_lat_n     = num_patterns;
          prpg_n      = fix_seed(seed);
          misr_n      = '0;
          pass_n      = 1'b0;
          pat_cnt_n   = '0;
          shift_cnt_n = '0;
          state_n     = (num_patterns == '0) ? ST_DONE : ST_LOAD;
        end
      end

      // First load: nothing valid in the chain yet, so the MISR stays frozen
      ST_LOAD: begin
        busy        = 1'b1;
        NbarT       = 1'b1;
        scan_in     = prpg[0];
        prpg_n      = prpg_step;
        shift_cnt_n = shift_last ? '0 : shift_cnt + 1'b1;
        if (shift_last) state_n = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        busy      = 1'b1;
        pat_cnt_n = pat_inc;
        state_n   = (pat_inc == n_lat) ? ST_FLUSH : ST_SHIFT;
      end

      // Overlapped unload of the previous response and load of the next pattern
      ST_SHIFT: begin
        busy        = 1'b1;
        NbarT       = 1'b1;
        scan_in     = prpg[0];
        prpg_n      = prpg_step;
        misr_n      = misr_step;
        shift_cnt_n = shift_last ? '0 : shift_cnt + 1'b1;
        if (shift_last) state_n = ST_CAPTURE;
      end

      ST_FLUSH: begin
        busy        = 1'b1;
        NbarT       = 1'b1;
        misr_n      = misr_step;
        shift_cnt_n = shift_last ? '0 : shift_cnt + 1'b1;
        if (shift_last) state_n = ST_COMPARE;
      end

      ST_COMPARE: begin
        busy    = 1'b1;
        pass_n  = (misr == golden_sig);
        state_n = ST_DONE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    test_active = busy;
  end

endmodule

// File: tb/tb_partial_scan_ctrl.sv
// tb/tb_partial_scan_ctrl.sv - self-checking bench with a 4-flop chain model and expected-output scoreboard
module tb_partial_scan_ctrl;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        test_go;
  logic [7:0]  num_patterns;
  logic [15:0] seed;
  logic [15:0] golden_sig;
  logic        scan_out;
  logic        NbarT;
  logic        scan_in;
  logic        test_active;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  logic [L-1:0] chain = '0;
  logic [1:0]   exp_q[$];
  logic [2:0]   obs_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  partial_scan_ctrl #(.CHAIN_LEN(L), .PAT_W(8), .SIG_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .test_go      (test_go),
    .num_patterns (num_patterns),
    .seed         (seed),
    .golden_sig   (golden_sig),
    .scan_out     (scan_out),
    .NbarT        (NbarT),
    .scan_in      (scan_in),
    .test_active  (test_active),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  always #5 clk = ~clk;

  // Stand-in for the scanned fourFunc registers: shift toward bit0, functional capture XORs 8'h5A
  always @(posedge clk) chain <= NbarT ? {scan_in, chain[L-1:1]} : chain ^ 4'hA;
  assign scan_out = chain[0];

  function automatic logic [15:0] m_prpg(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic b);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000) ^ {15'b0, b};
  endfunction

  task automatic build_expect(input logic [7:0] n, input logic [15:0] sd, output logic [15:0] sig);
    logic [15:0]  lf;
    logic [15:0]  m;
    logic [L-1:0] ch;
    logic         b;
    exp_q.delete();
    lf = (sd == 16'h0) ? 16'hACE1 : sd;
    ch = '0;
    m  = '0;
    for (int i = 0; i < L; i++) begin
      exp_q.push_back({1'b1, lf[0]});
      ch = {lf[0], ch[L-1:1]};
      lf = m_prpg(lf);
    end
    for (int p = 1; p <= int'(n); p++) begin
      exp_q.push_back(2'b00);
      ch = ch ^ 4'hA;
      for (int i = 0; i < L; i++) begin
        b = (p < int'(n)) ? lf[0] : 1'b0;
        exp_q.push_back({1'b1, b});
        m  = m_misr(m, ch[0]);
        ch = {b, ch[L-1:1]};
        if (p < int'(n)) lf = m_prpg(lf);
      end
    end
    if (n != 8'd0) exp_q.push_back(2'b00);
    sig = m;
  endtask

  task automatic run_session(input logic [7:0] n, input logic [15:0] sd, input logic [15:0] gold,
                             input int go_again_at, output int cyc, output logic [15:0] sig,
                             output logic p, output bit tmo);
    obs_q.delete();
    cyc = 0;
    tmo = 1'b1;
    @(negedge clk);
    num_patterns = n;
    seed         = sd;
    golden_sig   = gold;
    test_go      = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      test_go = 1'b0;
      if (busy) begin
        obs_q.push_back({test_active, NbarT, scan_in});
        cyc++;
        if (cyc == go_again_at) test_go = 1'b1;
      end else if (done) begin
        tmo = 1'b0;
        break;
      end
    end
    test_go = 1'b0;
    sig = signature;
    p   = pass;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (NbarT !== 1'b0) $display("FAIL reset_nbart got %b want 0", NbarT); else n_pass++;
    n_checks++; if (scan_in !== 1'b0) $display("FAIL reset_scan_in got %b want 0", scan_in); else n_pass++;
    n_checks++; if (test_active !== 1'b0) $display("FAIL reset_test_active got %b want 0", test_active); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %b want 0", pass); else n_pass++;
    n_checks++; if (signature !== 16'h0) $display("FAIL reset_sig got %h want 0000", signature); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_pattern(input bit bad_golden);
    logic [15:0] gsig, sig, gold;
    logic        p;
    int          cyc;
    bit          tmo;
    logic [1:0]  e;
    logic [2:0]  o;
    build_expect(8'd1, 16'h0001, gsig);
    gold = bad_golden ? (gsig ^ 16'h0008) : gsig;
    run_session(8'd1, 16'h0001, gold, 0, cyc, sig, p, tmo);
    n_checks++; if (tmo) $display("FAIL single_done_timeout bad=%0d", bad_golden); else n_pass++;
    n_checks++; if (cyc != 10) $display("FAIL single_busy_len got %0d want 10", cyc); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL single_sb_len got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o[2:1] !== {1'b1, e[1]} || (e[1] && o[0] !== e[0]))
        $display("FAIL single_cycle got act/nbart/si=%b want nbart/si=%b", o, e);
      else n_pass++;
    end
    n_checks++; if (p !== !bad_golden) $display("FAIL single_pass bad=%0d got %b want %b", bad_golden, p, !bad_golden); else n_pass++;
    n_checks++; if (sig !== gsig) $display("FAIL single_sig got %h want %h", sig, gsig); else n_pass++;
  endtask

  task automatic test_seed_zero();
    logic [15:0] gsig, sig;
    logic [3:0]  ace_bits;
    logic        p;
    int          cyc, caps;
    bit          tmo;
    logic [1:0]  e;
    logic [2:0]  o;
    ace_bits = 4'b0001;
    build_expect(8'd3, 16'h0000, gsig);
    run_session(8'd3, 16'h0000, gsig, 0, cyc, sig, p, tmo);
    n_checks++; if (tmo) $display("FAIL seed0_done_timeout"); else n_pass++;
    n_checks++; if (cyc != 20) $display("FAIL seed0_busy_len got %0d want 20", cyc); else n_pass++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i][0] !== ace_bits[i]) $display("FAIL seed0_scan_in[%0d] got %b want %b", i, obs_q[i][0], ace_bits[i]);
      else n_pass++;
    end
    caps = 0;
    for (int i = 0; i + 1 < obs_q.size(); i++) if (obs_q[i][1] === 1'b0) caps++;
    n_checks++; if (caps != 3) $display("FAIL seed0_captures got %0d want 3", caps); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o[2:1] !== {1'b1, e[1]} || (e[1] && o[0] !== e[0]))
        $display("FAIL seed0_cycle got act/nbart/si=%b want nbart/si=%b", o, e);
      else n_pass++;
    end
    n_checks++; if (p !== 1'b1) $display("FAIL seed0_pass got %b want 1", p); else n_pass++;
    n_checks++; if (sig !== gsig) $display("FAIL seed0_sig got %h want %h", sig, gsig); else n_pass++;
  endtask

  task automatic test_zero_patterns();
    @(negedge clk);
    num_patterns = 8'd0;
    seed         = 16'h1111;
    test_go      = 1'b1;
    @(negedge clk);
    test_go = 1'b0;
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done got %b want 1", done); else n_pass++;
    n_checks++; if (pass !== 1'b0) $display("FAIL zero_pass got %b want 0", pass); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy got %b want 0", busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (NbarT !== 1'b0) $display("FAIL zero_nbart[%0d] got %b want 0", i, NbarT); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] gsig, sig;
    logic        p;
    int          cyc;
    bit          tmo, hit;
    @(negedge clk);
    num_patterns = 8'd3;
    seed         = 16'h0001;
    test_go      = 1'b1;
    cyc = 0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      test_go = 1'b0;
      if (busy) cyc++;
      if (cyc == 7) begin hit = 1'b1; break; end
    end
    n_checks++; if (!hit) $display("FAIL rstmid_reach_shift got cyc=%0d want 7", cyc); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (NbarT !== 1'b0) $display("FAIL rstmid_nbart got %b want 0", NbarT); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else n_pass++;
    n_checks++; if (signature !== 16'h0) $display("FAIL rstmid_sig got %h want 0000", signature); else n_pass++;
    build_expect(8'd3, 16'h0001, gsig);
    run_session(8'd3, 16'h0001, gsig, 0, cyc, sig, p, tmo);
    n_checks++; if (tmo) $display("FAIL rstmid_rerun_timeout"); else n_pass++;
    n_checks++; if (cyc != 20) $display("FAIL rstmid_rerun_len got %0d want 20", cyc); else n_pass++;
    n_checks++; if (p !== 1'b1) $display("FAIL rstmid_rerun_pass got %b want 1", p); else n_pass++;
    n_checks++; if (sig !== gsig) $display("FAIL rstmid_rerun_sig got %h want %h", sig, gsig); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] gsig, sig;
    logic        p;
    int          cyc;
    bit          tmo;
    logic [1:0]  e;
    logic [2:0]  o;
    build_expect(8'd3, 16'h1234, gsig);
    run_session(8'd3, 16'h1234, gsig, 6, cyc, sig, p, tmo);
    n_checks++; if (tmo) $display("FAIL regō_timeout"); else n_pass++;
    n_checks++; if (cyc != 20) $display("FAIL rego_busy_len got %0d want 20", cyc); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o[2:1] !== {1'b1, e[1]} || (e[1] && o[0] !== e[0]))
        $display("FAIL rego_cycle got act/nbart/si=%b want nbart/si=%b", o, e);
      else n_pass++;
    end
    n_checks++; if (sig !== gsig) $display("FAIL rego_sig got %h want %h", sig, gsig); else n_pass++;
    n_checks++; if (p !== 1'b1) $display("FAIL rego_pass got %b want 1", p); else n_pass++;
    // Restart directly from DONE with a different seed
    build_expect(8'd2, 16'hBEEF, gsig);
    run_session(8'd2, 16'hBEEF, gsig, 0, cyc, sig, p, tmo);
    n_checks++; if (tmo) $display("FAIL restart_timeout"); else n_pass++;
    n_checks++; if (cyc != 15) $display("FAIL restart_busy_len got %0d want 15", cyc); else n_pass++;
    n_checks++; if (sig !== gsig) $display("FAIL restart_sig got %h want %h", sig, gsig); else n_pass++;
    n_checks++; if (p !== 1'b1) $display("FAIL restart_pass got %b want 1", p); else n_pass++;
  endtask

  task automatic test_max_patterns();
    logic [15:0] gsig, sig;
    logic        p;
    int          cyc;
    bit          tmo;
    build_expect(8'd255, 16'h00FF, gsig);
    run_session(8'd255, 16'h00FF, gsig, 0, cyc, sig, p, tmo);
    n_checks++; if (tmo) $display("FAIL max_timeout"); else n_pass++;
    n_checks++; if (cyc != 1280) $display("FAIL max_busy_len got %0d want 1280", cyc); else n_pass++;
    n_checks++; if (sig !== gsig) $display("FAIL max_sig got %h want %h", sig, gsig); else n_pass++;
    n_checks++; if (p !== 1'b1) $display("FAIL max_pass got %b want 1", p); else n_pass++;
  endtask

  initial begin
    rst          = 1'b1;
    test_go      = 1'b0;
    num_patterns = 8'd0;
    seed         = 16'h0;
    golden_sig   = 16'h0;
    test_reset();
    test_single_pattern(1'b0);
    test_single_pattern(1'b1);
    test_seed_zero();
    test_zero_patterns();
    test_reset_mid();
    test_back_to_back();
    test_max_patterns();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/partial_scan_ctrl.md
Name: partial_scan_ctrl

Overview:
Test controller for partial-scan testing of the fourFunc arithmetic datapath (shared adder/multiplier, scanned registers). It sequences scan-load, functional capture and scan-unload through the NbarT mode select. Stimulus comes from an internal LFSR pattern generator. Unloaded responses are compacted in a MISR, compared against a golden signature, and reported as a single pass flag. It sits beside fourFunc; the system or bench starts a session with test_go.

Parameters:
CHAIN_LEN, 16, number of scan flops in the partial chain (>=2)
PAT_W, 8, width of the pattern-count input
SIG_W, 16, LFSR/MISR width (fixed polynomial for 16; other widths not supported)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
test_go  in  1  start session; sampled only in IDLE/DONE
num_patterns  in  PAT_W  patterns to apply; latched on accepted test_go
seed  in  SIG_W  LFSR seed; latched on accepted test_go
golden_sig  in  SIG_W  expected MISR value; sampled in COMPARE
scan_out  in  1  serial output of fourFunc scan chain
NbarT  out  1  0 = normal/functional, 1 = test (scan shift)
scan_in  out  1  serial input to scan chain
test_active  out  1  high from accepted test_go through COMPARE; muxes fourFunc primary inputs (start=0, func/x held)
busy  out  1  session in progress
done  out  1  session finished; held until next accepted test_go or rst
pass  out  1  valid when done=1
signature  out  SIG_W  current MISR value

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; NbarT=0, scan_in=0, test_active=0, busy=0, done=0, pass=0; MISR=0; counters=0. Reset mid-session aborts immediately; chain contents are don't-care.
- States: IDLE, LOAD, CAPTURE, SHIFT, FLUSH, COMPARE, DONE.
- IDLE/DONE + test_go=1:
  - Latch num_patterns and seed. Seed 0 is replaced by 16'hACE1.
  - Clear MISR and done.
  - If num_patterns=0: go to DONE with pass=0 and done=1 the next cycle; NbarT never asserted.
  - Else go to LOAD.
- LOAD: CHAIN_LEN cycles, NbarT=1, scan_in=LFSR bit0, LFSR advances each cycle, MISR disabled (first load unloads nothing valid). Then go to CAPTURE.
- CAPTURE: exactly 1 cycle, NbarT=0, LFSR and MISR hold, pattern counter +1. If count==num_patterns go to FLUSH, else go to SHIFT.
- SHIFT: CHAIN_LEN cycles, NbarT=1, scan_in=LFSR bit0, LFSR advances, MISR absorbs scan_out every cycle (overlapped load/unload). Then go to CAPTURE.
- FLUSH: CHAIN_LEN cycles, NbarT=1, scan_in=0, LFSR holds, MISR absorbs scan_out. Then go to COMPARE.
- COMPARE: 1 cycle, NbarT=0. Register pass = (MISR == golden_sig). Go to DONE.
- DONE: done=1, busy=0, pass and signature held.
- busy=1 in LOAD..COMPARE. Busy length = CHAIN_LEN*(N+1) + N + 1 cycles.
- test_go while busy=1 is ignored.
- LFSR: Fibonacci, taps x^16+x^14+x^13+x^11+1, shift toward bit0, feedback into bit15.
- MISR: same polynomial, Galois form; next = (sig>>1) ^ (sig[0] ? POLY : 0) ^ {15'b0, scan_out}.
- Shift counter wraps 0..CHAIN_LEN-1. Pattern counter is PAT_W bits; num_patterns = 2^PAT_W-1 is legal, with no overflow.

Decomposition:
- Package scan_test_pkg: state enum, SIG_W, LFSR_POLY=16'hB400 (Galois mask), SEED_DEFAULT=16'hACE1.
- One sub-module, lfsr16_step, instantiated twice: mode parameter selects PRPG (Fibonacci) or MISR (Galois with serial input). The controller FSM and counters stay in partial_scan_ctrl.

Test Plan:
- CHAIN_LEN=4, N=1, seed=1, bench chain model (4-bit shift register, capture = x^8'h5A of its contents) -> NbarT pattern 1111 0 1111 0, busy high exactly 10 cycles, done=1 on cycle 11; pass=1 with golden from bench model.
- Same stimulus, golden_sig bit3 flipped -> done=1, pass=0, signature unchanged from the passing run.
- CHAIN_LEN=4, N=3, seed=0 -> first 4 scan_in bits equal bit0 of the ACE1 LFSR sequence (1,0,0,0); busy = 4*4+3+1 = 20 cycles; exactly 3 CAPTURE cycles.
- num_patterns=0, test_go pulse -> next cycle done=1, pass=0, busy=0; NbarT stays 0 throughout.
- rst=1 during 2nd SHIFT cycle -> next cycle NbarT=0, busy=0, done=0, signature=0. A new test_go then completes normally with pass=1.
- test_go pulsed again during SHIFT -> ignored; cycle count and signature identical to a single-go run.
